serial_negate_ctrl: RTL and testbench

//   Word-level controller for a bit-serial two's-complement negator. Accepts a

---
 rtl/serial_neg_pkg.sv | 10 +
 rtl/serial_tc_cell.sv | 25 ++
 rtl/serial_negate_ctrl.sv | 115 +++++++++++
 tb/tb_serial_negate_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_neg_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement negator.
package serial_neg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sn_state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_tc_cell.sv
// Bit-serial two's-complement cell: passes bits until the first 1, inverts afterwards.
// Output is combinational from b_in; seen_one is registered, clr is synchronous.
module serial_tc_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic b_in,
  output logic b_out
);

  logic r_seen_one;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else begin
      r_seen_one <= r_seen_one | b_in;
    end
  end

  assign b_out = r_seen_one ? ~b_in : b_in;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level negator around serial_tc_cell: result valid WIDTH edges after accept, held until out_ready.
// One word in flight (in_ready only in IDLE); optional ovf output with SERIAL_NEG_OVF_EN.
module serial_negate_ctrl
  import serial_neg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef SERIAL_NEG_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sn_state_t        r_state;
  sn_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_cell_in;
  logic             w_cell_out;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_cell_in = (r_state == SHIFT) ? r_src[0] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by reset so a producer never sees an accept during reset.
  always_comb begin
    in_ready  = (r_state == IDLE) && !reset;
    out_valid = (r_state == DONE);
    busy      = (r_state == SHIFT) || (r_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_src <= in_data;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_src <= r_src >> 1;
          r_res <= {w_cell_out, r_res[WIDTH-1:1]};
          if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_res;

  serial_tc_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .clr   (w_accept),
    .b_in  (w_cell_in),
    .b_out (w_cell_out)
  );

`ifdef SERIAL_NEG_OVF_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= (in_data == MIN_NEG);
    end else if ((r_state == DONE) && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_negate_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SERIAL_NEG_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_negate_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SERIAL_NEG_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Called at #1 after an edge with the DUT idle; returns result, ovf and accept-to-valid edges.
  task automatic do_word(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] res,
                         output logic res_ovf, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
`ifdef SERIAL_NEG_OVF_EN
    res_ovf = ovf;
`else
    res_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got %h want 00", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
`ifdef SERIAL_NEG_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf); end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res;
    logic             o;
    int               lat;
    do_word(8'h05, res, o, lat);
    n_cmp++; if (lat !== WIDTH) begin n_err++; $display("FAIL basic_latency got %0d want %0d", lat, WIDTH); end
    n_cmp++; if (res !== 8'hFB) begin n_err++; $display("FAIL basic_05 got %h want FB", res); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_back_idle got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
`ifdef SERIAL_NEG_OVF_EN
    n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL ovf_05 got %b want 0", o); end
`endif
  endtask

  task automatic test_values();
    logic [WIDTH-1:0] vin [3] = '{8'h00, 8'hFF, 8'h7F};
    logic [WIDTH-1:0] vexp[3] = '{8'h00, 8'h01, 8'h81};
    logic [WIDTH-1:0] res;
    logic             o;
    int               lat;
    for (int i = 0; i < 3; i++) begin
      do_word(vin[i], res, o, lat);
      n_cmp++;
      if (res !== vexp[i]) begin
        n_err++; $display("FAIL value_%h got %h want %h", vin[i], res, vexp[i]);
      end
    end
  endtask

  task automatic test_min_neg();
    logic [WIDTH-1:0] res;
    logic             o;
    int               lat;
    do_word(8'h80, res, o, lat);
    n_cmp++; if (res !== 8'h80) begin n_err++; $display("FAIL min_neg got %h want 80", res); end
`ifdef SERIAL_NEG_OVF_EN
    n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL ovf_80 got %b want 1", o); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got %b want 0", ovf); end
`endif
  endtask

  task automatic test_hold();
    int lat;
    in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1;
    in_data = 8'h77;  // keep in_valid high: must be ignored outside IDLE
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy_shift got %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== WIDTH) begin n_err++; $display("FAIL hold_latency got %0d want %0d", lat, WIDTH); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_%0d got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== 8'hCD) begin n_err++; $display("FAIL hold_data_%0d got %h want CD", i, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready_%0d got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_no_bypass got %b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_idle got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] res;
    logic             o;
    int               lat;
    in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", out_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle got %b want 1", in_ready); end
    @(posedge clk); #1;
    do_word(8'h10, res, o, lat);
    n_cmp++; if (res !== 8'hF0) begin n_err++; $display("FAIL midrst_next got %h want F0", res); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] res[2];
    int               acc[2];
    int               n_acc = 0;
    int               n_res = 0;
    bit               took;
    in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_res < 2; cyc++) begin
      took = 1'b0;
      if (out_valid) begin res[n_res] = out_data; n_res++; end
      if (in_ready && n_acc < 2) begin acc[n_acc] = cyc; n_acc++; took = 1'b1; end
      @(posedge clk); #1;
      if (took) begin
        if (n_acc == 1) in_data = 8'h02;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (n_res !== 2) begin n_err++; $display("FAIL b2b_results got %0d want 2", n_res); end
    if (n_res == 2) begin
      n_cmp++; if (res[0] !== 8'hFF) begin n_err++; $display("FAIL b2b_first got %h want FF", res[0]); end
      n_cmp++; if (res[1] !== 8'hFE) begin n_err++; $display("FAIL b2b_second got %h want FE", res[1]); end
    end
    if (n_acc == 2) begin
      n_cmp++;
      if (acc[1] - acc[0] !== WIDTH + 2) begin
        n_err++; $display("FAIL b2b_interval got %0d want %0d", acc[1] - acc[0], WIDTH + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_min_neg();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
